// File: rtl/io_mmio_ctrl_pkg.sv
// Shared definitions for the memory-mapped I/O controller.
// Holds the I/O address map, the STATUS bit positions and the address decoder
// used by io_mmio_ctrl.
package io_mmio_ctrl_pkg;

  // I/O register addresses; decoded on all 32 address bits.
  localparam logic [31:0] IO_STATUS = 32'h8000_0000;
  localparam logic [31:0] IO_RXDATA = 32'h8000_0004;
  localparam logic [31:0] IO_TXDATA = 32'h8000_0008;
  localparam logic [31:0] IO_CYCLES = 32'h8000_0010;
  localparam logic [31:0] IO_INSTS  = 32'h8000_0014;
  localparam logic [31:0] IO_CNTCLR = 32'h8000_0018;

  // STATUS register bit indices.
  localparam int unsigned IO_ST_TX_EMPTY = 0;
  localparam int unsigned IO_ST_RX_AVAIL = 1;
  localparam int unsigned IO_ST_TX_DROP  = 2;

  typedef enum logic [2:0] {
    RegNone,
    RegStatus,
    RegRxdata,
    RegTxdata,
    RegCycles,
    RegInsts,
    RegCntclr
  } io_reg_e;

  function automatic io_reg_e io_decode(input logic [31:0] addr);
    io_reg_e sel;
    sel = RegNone;
    unique case (addr)
      IO_STATUS: sel = RegStatus;
      IO_RXDATA: sel = RegRxdata;
      IO_TXDATA: sel = RegTxdata;
      IO_CYCLES: sel = RegCycles;
      IO_INSTS:  sel = RegInsts;
      IO_CNTCLR: sel = RegCntclr;
      default:   sel = RegNone;
    endcase
    return sel;
  endfunction

  function automatic logic [31:0] io_status_word(input logic tx_empty, input logic rx_avail,
                                                 input logic tx_drop);
    logic [31:0] w;
    w = '0;
    w[IO_ST_TX_EMPTY] = tx_empty;
    w[IO_ST_RX_AVAIL] = rx_avail;
    w[IO_ST_TX_DROP]  = tx_drop;
    return w;
  endfunction

endpackage

// File: rtl/io_rx_fifo.sv
// Byte FIFO buffering the UART receive path.
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   push, din    write strobe and byte; ignored while full
//   pop          read strobe; ignored while empty
//   dout         head of the FIFO (combinational, stale when empty)
//   full, empty  occupancy flags
module io_rx_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] CntFull = DEPTH[AW:0];
  localparam logic [AW:0] CntOne = 1;
  localparam logic [AW-1:0] PtrOne = 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  assign full    = (cnt_q == CntFull);
  assign empty   = (cnt_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PtrOne;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrOne;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CntOne;
      2'b01:   cnt_d = cnt_q - CntOne;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: contents are only visible through a nonzero count.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/io_mmio_ctrl.sv
// Memory-mapped I/O controller for the 0x8xxxxxxx region.
// Decodes I/O loads/stores from the memory-control stage, returns registered
// load data (latency 1), bridges to a UART (buffered RX FIFO, single-entry TX
// holding register) and provides cycle and retired-instruction counters.
// Ports:
//   clk, rst                  clock and asynchronous active-high reset
//   Addr, Wdata               address and lane-shifted store data
//   Io_trans                  store byte enables (nonzero = store)
//   Io_recv                   load strobe
//   Inst_retire               one instruction retired this cycle
//   Rdata                     registered load data
//   uart_tx_data/valid/ready  TX byte handshake to the transmitter
//   uart_rx_data/valid/ready  RX byte handshake from the receiver
module io_mmio_ctrl
  import io_mmio_ctrl_pkg::*;
#(
  parameter int unsigned RX_DEPTH = 4,
  parameter int unsigned CNT_W    = 32  // at most 32; reads are zero-extended
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Addr,
  input  logic [31:0] Wdata,
  input  logic [3:0]  Io_trans,
  input  logic        Io_recv,
  input  logic        Inst_retire,
  output logic [31:0] Rdata,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready
);

  localparam logic [CNT_W-1:0] CntOne = 1;

  io_reg_e sel;

  logic [31:0]      rdata_q, rdata_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic             tx_drop_q, tx_drop_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] inst_q, inst_d;

  logic       rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0] rx_head;
  logic       tx_store, tx_load, tx_drop_evt, status_rd, cnt_clr;

  assign sel = io_decode(Addr);

  // RX path
  assign uart_rx_ready = ~rx_full;
  assign rx_push       = uart_rx_valid & ~rx_full;
  assign rx_pop        = Io_recv & (sel == RegRxdata) & ~rx_empty;

  io_rx_fifo #(
    .DEPTH(RX_DEPTH)
  ) u_rx_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (rx_push),
    .din  (uart_rx_data),
    .pop  (rx_pop),
    .dout (rx_head),
    .full (rx_full),
    .empty(rx_empty)
  );

  // TX path: a store on the handshake edge still sees the register as full.
  assign tx_store    = Io_trans[0] & (sel == RegTxdata);
  assign tx_load     = tx_store & ~tx_valid_q;
  assign tx_drop_evt = tx_store & tx_valid_q;
  assign status_rd   = Io_recv & (sel == RegStatus);
  assign cnt_clr     = (|Io_trans) & (sel == RegCntclr);

  always_comb begin
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    if (tx_load) begin
      tx_data_d  = Wdata[7:0];
      tx_valid_d = 1'b1;
    end else if (tx_valid_q && uart_tx_ready) begin
      tx_valid_d = 1'b0;
    end
  end

  // A drop on the same edge as the STATUS read that clears the flag wins.
  always_comb begin
    tx_drop_d = tx_drop_q;
    if (status_rd)   tx_drop_d = 1'b0;
    if (tx_drop_evt) tx_drop_d = 1'b1;
  end

  // Counters: clear beats increment.
  always_comb begin
    cyc_d  = cyc_q + CntOne;
    inst_d = Inst_retire ? (inst_q + CntOne) : inst_q;
    if (cnt_clr) begin
      cyc_d  = '0;
      inst_d = '0;
    end
  end

  // Load data mux; reads see pre-edge values of every register.
  always_comb begin
    rdata_d = rdata_q;
    if (Io_recv) begin
      case (sel)
        RegStatus: rdata_d = io_status_word(~tx_valid_q, ~rx_empty, tx_drop_q);
        RegRxdata: rdata_d = rx_empty ? 32'h0 : {24'h0, rx_head};
        RegCycles: rdata_d = 32'(cyc_q);
        RegInsts:  rdata_d = 32'(inst_q);
        default:   rdata_d = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q    <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      tx_drop_q  <= 1'b0;
      cyc_q      <= '0;
      inst_q     <= '0;
    end else begin
      rdata_q    <= rdata_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      tx_drop_q  <= tx_drop_d;
      cyc_q      <= cyc_d;
      inst_q     <= inst_d;
    end
  end

  assign Rdata         = rdata_q;
  assign uart_tx_data  = tx_data_q;
  assign uart_tx_valid = tx_valid_q;

endmodule
